// File: rtl/axi4_w_drop_sink_pkg.sv
// Shared constants and types for the W drop sink: B response codes,
// the B-channel source selector and the response rule for dropped bursts.
package axi4_w_drop_sink_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Which source currently owns the slave B channel.
  typedef enum logic [1:0] {
    B_IDLE   = 2'd0,
    B_LOCAL  = 2'd1,
    B_MASTER = 2'd2
  } b_src_e;

  // A dropped prefetch that hit is answered OKAY; every other drop is an error.
  function automatic logic [1:0] drop_resp(input logic prefetch, input logic hit);
    return (prefetch & hit) ? RESP_OKAY : RESP_SLVERR;
  endfunction

endpackage

// File: rtl/axi4_w_drop_sink_if.sv
// W and B channel bundle. The master modport drives W and accepts B;
// the slave modport accepts W and drives B.
interface axi4_w_drop_sink_if #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_USER_WIDTH = 4
);

  logic [AXI_DATA_WIDTH-1:0]   wdata;
  logic [AXI_DATA_WIDTH/8-1:0] wstrb;
  logic                        wlast;
  logic [AXI_USER_WIDTH-1:0]   wuser;
  logic                        wvalid;
  logic                        wready;

  logic [AXI_ID_WIDTH-1:0]     bid;
  logic [1:0]                  bresp;
  logic [AXI_USER_WIDTH-1:0]   buser;
  logic                        bvalid;
  logic                        bready;

  modport master (
    output wdata, wstrb, wlast, wuser, wvalid,
    input  wready,
    input  bid, bresp, buser, bvalid,
    output bready
  );

  modport slave (
    input  wdata, wstrb, wlast, wuser, wvalid,
    output wready,
    output bid, bresp, buser, bvalid,
    input  bready
  );

endinterface

// File: rtl/axi4_w_drop_sink_buffer.sv
// Small first-word-fall-through FIFO holding the AW forward/drop decisions.
// The head entry is visible combinationally so W routing has no latency.
module axi4_w_drop_sink_buffer #(
  parameter int DATA_WIDTH       = 7,
  parameter int LOG_BUFFER_DEPTH = 3
) (
  input  logic                  axi4_aclk,
  input  logic                  axi4_arstn,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  localparam int DEPTH = 1 << LOG_BUFFER_DEPTH;

  logic [DATA_WIDTH-1:0]       mem [DEPTH];
  logic [LOG_BUFFER_DEPTH-1:0] wr_ptr_q;
  logic [LOG_BUFFER_DEPTH-1:0] rd_ptr_q;
  logic [LOG_BUFFER_DEPTH:0]   count_q;
  logic                        push;
  logic                        pop;

  // A full FIFO refuses pushes even when the head pops in the same cycle.
  assign ready_o = (count_q != (LOG_BUFFER_DEPTH + 1)'(DEPTH));
  assign valid_o = (count_q != '0);
  assign data_o  = mem[rd_ptr_q];
  assign push    = valid_i & ready_o;
  assign pop     = valid_o & ready_i;

  // Storage needs no reset: only entries below count_q are ever observed.
  always_ff @(posedge axi4_aclk) begin
    if (push) begin
      mem[wr_ptr_q] <= data_i;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/axi4_w_drop_sink.sv
// Write-path drop sink. AW decisions are queued in AW order; W bursts of
// forwarded AWs pass to the master port, W bursts of dropped AWs are
// swallowed here and answered with a locally generated B response that is
// merged with the master-side B stream onto the slave port.
module axi4_w_drop_sink
  import axi4_w_drop_sink_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_USER_WIDTH = 4,
  parameter int BUFFER_DEPTH   = 8
) (
  input  logic                    axi4_aclk,
  input  logic                    axi4_arstn,
  input  logic                    fwd_i,
  input  logic                    drop_i,
  input  logic [AXI_ID_WIDTH-1:0] id_i,
  input  logic                    prefetch_i,
  input  logic                    hit_i,
  output logic                    done_o,
  axi4_w_drop_sink_if.slave       s_axi4,
  axi4_w_drop_sink_if.master      m_axi4
);

  localparam int ENTRY_WIDTH     = 3 + AXI_ID_WIDTH;
  localparam int LOG_DEPTH       = $clog2(BUFFER_DEPTH);
  localparam int W_PAYLOAD_WIDTH = AXI_DATA_WIDTH + AXI_DATA_WIDTH/8 + 1 + AXI_USER_WIDTH;

  // Order FIFO and its head entry {drop, prefetch, hit, id}
  logic                    fifo_ready;
  logic                    fifo_pop;
  logic                    head_valid;
  logic [ENTRY_WIDTH-1:0]  push_entry;
  logic [ENTRY_WIDTH-1:0]  head_entry;
  logic                    head_drop;
  logic                    head_prefetch;
  logic                    head_hit;
  logic [AXI_ID_WIDTH-1:0] head_id;

  // W routing
  logic [W_PAYLOAD_WIDTH-1:0] w_payload;
  logic                       w_last_hs;
  logic                       hold_free;
  logic                       local_load;

  // Local B hold register and merge FSM
  logic                    hold_full_q;
  logic [AXI_ID_WIDTH-1:0] hold_id_q;
  logic [1:0]              hold_resp_q;
  logic                    hold_clear;
  b_src_e                  b_src_q;
  logic                    sel_local;
  logic                    sel_master;

  assign push_entry = {drop_i, prefetch_i, hit_i, id_i};
  assign done_o     = (fwd_i | drop_i) & fifo_ready;

  axi4_w_drop_sink_buffer #(
    .DATA_WIDTH       (ENTRY_WIDTH),
    .LOG_BUFFER_DEPTH (LOG_DEPTH)
  ) u_order_fifo (
    .axi4_aclk  (axi4_aclk),
    .axi4_arstn (axi4_arstn),
    .data_i     (push_entry),
    .valid_i    (fwd_i | drop_i),
    .ready_o    (fifo_ready),
    .data_o     (head_entry),
    .valid_o    (head_valid),
    .ready_i    (fifo_pop)
  );

  assign head_drop     = head_entry[ENTRY_WIDTH-1];
  assign head_prefetch = head_entry[ENTRY_WIDTH-2];
  assign head_hit      = head_entry[ENTRY_WIDTH-3];
  assign head_id       = head_entry[AXI_ID_WIDTH-1:0];

  // Payload always follows the slave side; only wvalid is gated per route.
  assign w_payload = {s_axi4.wdata, s_axi4.wstrb, s_axi4.wlast, s_axi4.wuser};
  assign {m_axi4.wdata, m_axi4.wstrb, m_axi4.wlast, m_axi4.wuser} = w_payload;

  // A freed hold slot may be refilled in the same cycle it is cleared.
  assign hold_free = ~hold_full_q | hold_clear;

  // Route W by the head decision: stall when no decision, pass or sink otherwise.
  always_comb begin
    m_axi4.wvalid = 1'b0;
    s_axi4.wready = 1'b0;
    if (head_valid) begin
      if (!head_drop) begin
        m_axi4.wvalid = s_axi4.wvalid;
        s_axi4.wready = m_axi4.wready;
      end else begin
        s_axi4.wready = ~s_axi4.wlast | hold_free;
      end
    end
  end

  assign w_last_hs  = s_axi4.wvalid & s_axi4.wready & s_axi4.wlast;
  assign fifo_pop   = head_valid & w_last_hs;
  assign local_load = fifo_pop & head_drop;

  // Local B owns the channel while latched, or from IDLE whenever the hold is full.
  assign sel_local  = (b_src_q == B_LOCAL) | ((b_src_q == B_IDLE) & hold_full_q);
  assign sel_master = (b_src_q == B_MASTER) |
                      ((b_src_q == B_IDLE) & ~hold_full_q & m_axi4.bvalid);
  assign hold_clear = sel_local & s_axi4.bready;

  // Drive slave B from the selected source; master B waits while local owns it.
  always_comb begin
    s_axi4.bvalid = 1'b0;
    s_axi4.bid    = m_axi4.bid;
    s_axi4.bresp  = m_axi4.bresp;
    s_axi4.buser  = m_axi4.buser;
    m_axi4.bready = 1'b0;
    if (sel_local) begin
      s_axi4.bvalid = 1'b1;
      s_axi4.bid    = hold_id_q;
      s_axi4.bresp  = hold_resp_q;
      s_axi4.buser  = {AXI_USER_WIDTH{1'b0}};
    end else if (sel_master) begin
      s_axi4.bvalid = m_axi4.bvalid;
      m_axi4.bready = s_axi4.bready;
    end
  end

  // Hold register: latch the local response on a sunk wlast, release on handshake.
  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) begin
      hold_full_q <= 1'b0;
      hold_id_q   <= '0;
      hold_resp_q <= RESP_OKAY;
    end else if (local_load) begin
      hold_full_q <= 1'b1;
      hold_id_q   <= head_id;
      hold_resp_q <= drop_resp(head_prefetch, head_hit);
    end else if (hold_clear) begin
      hold_full_q <= 1'b0;
    end
  end

  // B merge FSM: lock the chosen source until its response is accepted.
  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) begin
      b_src_q <= B_IDLE;
    end else begin
      case (b_src_q)
        B_IDLE: begin
          if (hold_full_q) begin
            if (!s_axi4.bready) b_src_q <= B_LOCAL;
          end else if (m_axi4.bvalid && !s_axi4.bready) begin
            b_src_q <= B_MASTER;
          end
        end
        B_LOCAL: begin
          if (s_axi4.bready) b_src_q <= B_IDLE;
        end
        B_MASTER: begin
          if (m_axi4.bvalid && s_axi4.bready) b_src_q <= B_IDLE;
        end
        default: b_src_q <= B_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_w_drop_sink.sv
// Bench for the W drop sink: directed scenarios followed by a randomized
// phase, all checked against a queue-based model of AW decisions.
module tb_axi4_w_drop_sink;

  logic       clk = 1'b0;
  logic       rstn;
  logic       fwd, drop, pf, hit;
  logic [3:0] id;
  logic       done;

  int checks = 0;
  int errors = 0;
  int m_obs  = 0;

  typedef struct {
    bit         drop;
    logic [3:0] id;
    logic [1:0] resp;
  } dec_t;
  dec_t dec_q[$];

  axi4_w_drop_sink_if #(.AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(4), .AXI_USER_WIDTH(4)) s_if ();
  axi4_w_drop_sink_if #(.AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(4), .AXI_USER_WIDTH(4)) m_if ();

  axi4_w_drop_sink #(
    .AXI_DATA_WIDTH (32),
    .AXI_ID_WIDTH   (4),
    .AXI_USER_WIDTH (4),
    .BUFFER_DEPTH   (8)
  ) dut (
    .axi4_aclk  (clk),
    .axi4_arstn (rstn),
    .fwd_i      (fwd),
    .drop_i     (drop),
    .id_i       (id),
    .prefetch_i (pf),
    .hit_i      (hit),
    .done_o     (done),
    .s_axi4     (s_if),
    .m_axi4     (m_if)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one AW decision for a single cycle; model accepts it if not full.
  task automatic decide(input bit is_drop, input logic [3:0] did, input bit dpf, input bit dhit);
    bit exp_done;
    fwd  = !is_drop;
    drop = is_drop;
    id   = did;
    pf   = dpf;
    hit  = dhit;
    @(negedge clk);
    exp_done = (dec_q.size() < 8);
    chk("done_o", done, exp_done);
    $display("decision drop=%0d id=%0h done=%0d", is_drop, did, done);
    if (exp_done) dec_q.push_back('{is_drop, did, (dpf && dhit) ? 2'b00 : 2'b10});
    tick();
    fwd  = 1'b0;
    drop = 1'b0;
  endtask

  // Send one W burst against the model head; optionally check the local B.
  task automatic send_burst(input int nbeats, input bit rand_ready, input bit check_b);
    dec_t head;
    bit   got;
    if (dec_q.size() == 0) begin
      chk("burst_without_decision", 0, 1);
      return;
    end
    head = dec_q[0];
    for (int b = 0; b < nbeats; b++) begin
      s_if.wvalid = 1'b1;
      s_if.wdata  = $urandom;
      s_if.wstrb  = 4'($urandom);
      s_if.wlast  = (b == nbeats - 1);
      s_if.wuser  = 4'($urandom);
      got = 1'b0;
      for (int c = 0; c < 32 && !got; c++) begin
        m_if.wready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        if (m_if.wvalid && m_if.wready) m_obs++;
        if (!head.drop) begin
          chk("m_wvalid_fwd", m_if.wvalid, 1);
          chk("m_wpayload", {m_if.wdata, m_if.wstrb, m_if.wlast, m_if.wuser},
                            {s_if.wdata, s_if.wstrb, s_if.wlast, s_if.wuser});
          chk("s_wready_fwd", s_if.wready, m_if.wready);
          got = m_if.wready;
        end else begin
          chk("m_wvalid_sink", m_if.wvalid, 0);
          chk("s_wready_sink", s_if.wready, 1);
          got = 1'b1;
        end
        tick();
      end
      if (!got) chk("w_beat_timeout", 0, 1);
    end
    s_if.wvalid = 1'b0;
    s_if.wlast  = 1'b0;
    void'(dec_q.pop_front());
    $display("burst drop=%0d id=%0h beats=%0d", head.drop, head.id, nbeats);
    if (head.drop && check_b) begin
      @(negedge clk);
      chk("local_bvalid", s_if.bvalid, 1);
      chk("local_bid", s_if.bid, head.id);
      chk("local_bresp", s_if.bresp, head.resp);
      chk("local_buser", s_if.buser, 0);
      chk("local_m_bready", m_if.bready, 0);
      $display("local B id=%0h resp=%0h", s_if.bid, s_if.bresp);
      tick();
    end
  endtask

  // With no decision queued, W must stall and never reach the master.
  task automatic check_empty(input string tag);
    s_if.wvalid = 1'b1;
    s_if.wlast  = 1'b1;
    m_if.wready = 1'b1;
    @(negedge clk);
    chk({tag, "_s_wready"}, s_if.wready, 0);
    chk({tag, "_m_wvalid"}, m_if.wvalid, 0);
    $display("empty check %s wready=%0d", tag, s_if.wready);
    tick();
    s_if.wvalid = 1'b0;
    s_if.wlast  = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_s_wready"}, s_if.wready, 0);
    chk({tag, "_m_wvalid"}, m_if.wvalid, 0);
    chk({tag, "_s_bvalid"}, s_if.bvalid, 0);
    chk({tag, "_m_bready"}, m_if.bready, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    rstn = 1'b0;
    fwd = 1'b0; drop = 1'b0; pf = 1'b0; hit = 1'b0; id = '0;
    s_if.wvalid = 1'b1; s_if.wlast = 1'b1; s_if.wdata = '0; s_if.wstrb = '0; s_if.wuser = '0;
    s_if.bready = 1'b1;
    m_if.wready = 1'b1;
    m_if.bvalid = 1'b0; m_if.bid = '0; m_if.bresp = '0; m_if.buser = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    tick();
    rstn = 1'b1;
    s_if.wvalid = 1'b0; s_if.wlast = 1'b0;
    tick();

    // 1: forwarded burst passes through unchanged
    decide(0, 4'h1, 0, 0);
    send_burst(4, 0, 0);
    decide(0, 4'h2, 0, 0);
    send_burst(3, 1, 0);
    check_empty("after_fwd");

    // 2: dropped burst is sunk, SLVERR returned locally
    decide(1, 4'h3, 0, 0);
    send_burst(4, 0, 1);

    // 3: single-beat prefetch hit drop returns OKAY
    decide(1, 4'h5, 1, 1);
    send_burst(1, 0, 1);

    // 4: fwd, drop, fwd with 2, 3, 1 beats: only three beats reach master
    m_obs = 0;
    decide(0, 4'h0, 0, 0);
    decide(1, 4'h6, 1, 0);
    decide(0, 4'h0, 0, 0);
    send_burst(2, 0, 1);
    send_burst(3, 0, 1);
    send_burst(1, 0, 1);
    chk("master_beats", m_obs, 3);
    check_empty("after_mix");

    // 5: pending local B holds off master B until accepted
    s_if.bready = 1'b0;
    decide(1, 4'h7, 0, 0);
    send_burst(1, 0, 0);
    m_if.bvalid = 1'b1; m_if.bid = 4'h9; m_if.bresp = 2'b01; m_if.buser = 4'hA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_bvalid", s_if.bvalid, 1);
      chk("hold_bid", s_if.bid, 4'h7);
      chk("hold_m_bready", m_if.bready, 0);
      tick();
    end
    s_if.bready = 1'b1;
    @(negedge clk);
    chk("local_first_bid", s_if.bid, 4'h7);
    chk("local_first_bresp", s_if.bresp, 2'b10);
    chk("local_first_m_bready", m_if.bready, 0);
    $display("B local id=%0h accepted", s_if.bid);
    tick();
    @(negedge clk);
    chk("master_bvalid", s_if.bvalid, 1);
    chk("master_bid", s_if.bid, 4'h9);
    chk("master_bresp", s_if.bresp, 2'b01);
    chk("master_buser", s_if.buser, 4'hA);
    chk("master_m_bready", m_if.bready, 1);
    $display("B master id=%0h forwarded", s_if.bid);
    tick();
    m_if.bvalid = 1'b0;
    @(negedge clk);
    chk("b_idle_after_master", s_if.bvalid, 0);
    tick();

    // 6: nine drops with no W fill the FIFO; the ninth is refused
    for (int i = 0; i < 9; i++) decide(1, 4'(i), 0, 0);
    s_if.wvalid = 1'b1; s_if.wlast = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("mid_sink_wready", s_if.wready, 1);
      tick();
    end
    #2;
    rstn = 1'b0;
    s_if.wlast = 1'b1;
    @(negedge clk);
    check_idle_outputs("mid_reset");
    dec_q.delete();
    tick();
    rstn = 1'b1;
    s_if.wvalid = 1'b0; s_if.wlast = 1'b0;
    tick();
    check_empty("after_reset");
    decide(1, 4'hC, 1, 1);
    send_burst(2, 0, 1);

    // Randomized phase
    for (int it = 0; it < 40; it++) begin
      int ndec;
      ndec = $urandom_range(1, 3);
      for (int d = 0; d < ndec; d++)
        decide(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      while (dec_q.size() != 0) send_burst($urandom_range(1, 4), 1, 1);
    end
    check_empty("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
